// File: rtl/compressed_expander.sv
// RV32C-to-RV32I expander between realigner and decode: one-cycle latency through a main output register.
// A one-entry skid register absorbs a single beat of backpressure; in_ready is simply "skid empty".
module compressed_expander #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter bit          ILLEGAL_PASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        is_compressed,
    output logic        illegal
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        is_c;
        logic        ill;
    } slot_t;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam slot_t       IDLE = {RESET_PC, NOP, 1'b0, 1'b0};

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [15:0] c;
    logic [4:0]  rd, rs2, rd_p, rs1_p;
    logic [11:0] imm_4spn, imm_lw, imm6, imm_16sp, imm_lwsp, imm_swsp;
    logic [19:0] imm_lui;
    logic [20:0] imm_j;
    logic [12:0] imm_b;

    assign c     = inst_in[15:0];
    assign rd    = c[11:7];
    assign rs2   = c[6:2];
    assign rd_p  = {2'b01, c[4:2]};
    assign rs1_p = {2'b01, c[9:7]};

    assign imm_4spn = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00};
    assign imm_lw   = {5'b0, c[5], c[12:10], c[6], 2'b00};
    assign imm6     = {{6{c[12]}}, c[12], c[6:2]};
    assign imm_16sp = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
    assign imm_lui  = {{14{c[12]}}, c[12], c[6:2]};
    assign imm_lwsp = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
    assign imm_swsp = {4'b0, c[8:7], c[12:9], 2'b00};
    assign imm_j    = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
    assign imm_b    = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

    // ------------------------------------------------------------------
    // Expansion
    // ------------------------------------------------------------------
    logic [31:0] exp_inst;
    logic        exp_ill;

    always_comb begin
        exp_inst = NOP;
        exp_ill  = 1'b0;
        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin
                        exp_inst = {imm_4spn, 5'd2, 3'b000, rd_p, OP_IMM};
                        exp_ill  = (imm_4spn == 12'd0);
                    end
                    3'b010:  exp_inst = {imm_lw, rs1_p, 3'b010, rd_p, OP_LD};
                    3'b110:  exp_inst = {imm_lw[11:5], rd_p, rs1_p, 3'b010, imm_lw[4:0], OP_ST};
                    default: exp_ill  = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: exp_inst = {imm6, rd, 3'b000, rd, OP_IMM};
                    3'b001: exp_inst = {imm_j[20], imm_j[10:1], imm_j[11], imm_j[19:12], 5'd1, OP_JAL};
                    3'b010: exp_inst = {imm6, 5'd0, 3'b000, rd, OP_IMM};
                    3'b011: begin
                        if (rd == 5'd2) begin
                            exp_inst = {imm_16sp, 5'd2, 3'b000, 5'd2, OP_IMM};
                            exp_ill  = (imm_16sp == 12'd0);
                        end else begin
                            exp_inst = {imm_lui, rd, OP_LUI};
                            exp_ill  = (imm_lui == 20'd0);
                        end
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00: begin
                                exp_inst = {7'b0000000, c[6:2], rs1_p, 3'b101, rs1_p, OP_IMM};
                                exp_ill  = c[12];
                            end
                            2'b01: begin
                                exp_inst = {7'b0100000, c[6:2], rs1_p, 3'b101, rs1_p, OP_IMM};
                                exp_ill  = c[12];
                            end
                            2'b10: exp_inst = {imm6, rs1_p, 3'b111, rs1_p, OP_IMM};
                            default: begin
                                // c[12]=1 here is SUBW/ADDW or reserved: not RV32
                                exp_ill = c[12];
                                case (c[6:5])
                                    2'b00:   exp_inst = {7'b0100000, rd_p, rs1_p, 3'b000, rs1_p, OP_REG};
                                    2'b01:   exp_inst = {7'b0000000, rd_p, rs1_p, 3'b100, rs1_p, OP_REG};
                                    2'b10:   exp_inst = {7'b0000000, rd_p, rs1_p, 3'b110, rs1_p, OP_REG};
                                    default: exp_inst = {7'b0000000, rd_p, rs1_p, 3'b111, rs1_p, OP_REG};
                                endcase
                            end
                        endcase
                    end
                    3'b101: exp_inst = {imm_j[20], imm_j[10:1], imm_j[11], imm_j[19:12], 5'd0, OP_JAL};
                    3'b110: exp_inst = {imm_b[12], imm_b[10:5], 5'd0, rs1_p, 3'b000,
                                        imm_b[4:1], imm_b[11], OP_BR};
                    default: exp_inst = {imm_b[12], imm_b[10:5], 5'd0, rs1_p, 3'b001,
                                         imm_b[4:1], imm_b[11], OP_BR};
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        exp_inst = {7'b0000000, c[6:2], rd, 3'b001, rd, OP_IMM};
                        exp_ill  = c[12];
                    end
                    3'b010: begin
                        exp_inst = {imm_lwsp, 5'd2, 3'b010, rd, OP_LD};
                        exp_ill  = (rd == 5'd0);
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (rs2 == 5'd0) begin
                                exp_inst = {12'd0, rd, 3'b000, 5'd0, OP_JR};
                                exp_ill  = (rd == 5'd0);
                            end else begin
                                exp_inst = {7'b0000000, rs2, 5'd0, 3'b000, rd, OP_REG};
                            end
                        end else if (rs2 == 5'd0) begin
                            if (rd == 5'd0) exp_inst = 32'h0010_0073;
                            else            exp_inst = {12'd0, rd, 3'b000, 5'd1, OP_JR};
                        end else begin
                            exp_inst = {7'b0000000, rs2, rd, 3'b000, rd, OP_REG};
                        end
                    end
                    3'b110:  exp_inst = {imm_swsp[11:5], rs2, 5'd2, 3'b010, imm_swsp[4:0], OP_ST};
                    default: exp_ill  = 1'b1;
                endcase
            end
            default: begin
                exp_inst = inst_in;
                exp_ill  = 1'b0;
            end
        endcase
    end

    slot_t in_dat;

    always_comb begin
        in_dat.pc   = pc_in;
        in_dat.is_c = (inst_in[1:0] != 2'b11);
        in_dat.ill  = exp_ill;
        if (exp_ill)
            in_dat.inst = ILLEGAL_PASS ? {16'h0000, c} : NOP;
        else
            in_dat.inst = exp_inst;
    end

    // ------------------------------------------------------------------
    // Main register + skid register
    // ------------------------------------------------------------------
    slot_t main_dat, skid_dat;
    logic  main_vld, skid_vld;

    // An empty main register holds IDLE so pc_out reads RESET_PC whenever nothing is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= IDLE;
            skid_dat <= IDLE;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_dat <= IDLE;
        end else if (!main_vld || out_ready) begin
            if (skid_vld) begin
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (in_valid) begin
                main_vld <= 1'b1;
                main_dat <= in_dat;
            end else begin
                main_vld <= 1'b0;
                main_dat <= IDLE;
            end
        end else if (in_valid && !skid_vld) begin
            skid_vld <= 1'b1;
            skid_dat <= in_dat;
        end
    end

    assign in_ready      = !skid_vld;
    assign out_valid     = main_vld;
    assign pc_out        = main_dat.pc;
    assign inst_out      = main_dat.inst;
    assign is_compressed = main_dat.is_c;
    assign illegal       = main_dat.ill;

endmodule

// File: tb/tb_compressed_expander.sv
// Directed bench for compressed_expander: expansion vectors, backpressure/skid, flush and async reset.
module tb_compressed_expander;

    localparam logic [31:0] RPC = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] pc_in, inst_in, pc_out, inst_out;
    logic        is_compressed, illegal;

    int tests = 0;
    int fails = 0;

    compressed_expander #(.RESET_PC(RPC), .ILLEGAL_PASS(1'b1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .inst_in(inst_in),
        .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .inst_out(inst_out),
        .is_compressed(is_compressed), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] exp;
        logic        c;
        logic        ill;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{32'h0000_0085, 32'h0010_8093, 1'b1, 1'b0}; // c.addi x1,1
        vecs[1]  = '{32'h0000_852E, 32'h00B0_0533, 1'b1, 1'b0}; // c.mv x10,x11
        vecs[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1}; // all-zero halfword
        vecs[3]  = '{32'h0000_0013, 32'h0000_0013, 1'b0, 1'b0}; // bubble
        vecs[4]  = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_40C0, 32'h0044_A403, 1'b1, 1'b0}; // c.lw x8,4(x9)
        vecs[6]  = '{32'h0000_BFFD, 32'hFFFF_F06F, 1'b1, 1'b0}; // c.j -2
        vecs[7]  = '{32'h0000_6281, 32'h0000_6281, 1'b1, 1'b1}; // c.lui nzimm=0
        vecs[8]  = '{32'h0000_9005, 32'h0000_9005, 1'b1, 1'b1}; // c.srli shamt[5]=1
        vecs[9]  = '{32'h0000_6000, 32'h0000_6000, 1'b1, 1'b1}; // c.flw
        vecs[10] = '{32'h0000_C401, 32'h0004_0463, 1'b1, 1'b0}; // c.beqz x8,+8
        vecs[11] = '{32'h0000_717D, 32'hFF01_0113, 1'b1, 1'b0}; // c.addi16sp -16
        vecs[12] = '{32'h0000_C606, 32'h0011_2623, 1'b1, 1'b0}; // c.swsp x1,12
        vecs[13] = '{32'h0000_9002, 32'h0010_0073, 1'b1, 1'b0}; // c.ebreak
        vecs[14] = '{32'h0000_8002, 32'h0000_8002, 1'b1, 1'b1}; // c.jr x0

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc_in = '0; inst_in = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_pc", pc_out, RPC);
        check("rst_inst", inst_out, 32'h13);
        check("rst_is_c", is_compressed, 0);
        check("rst_illegal", illegal, 0);
        tick(); tick();
        reset = 1'b0;

        // Back-to-back vectors with out_ready held high: one per cycle
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            pc_in    = 32'h1000 + 32'(i * 4);
            inst_in  = vecs[i].inst;
            tick();
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_inst", i), inst_out, vecs[i].exp);
            check($sformatf("v%0d_is_c", i), is_compressed, 32'(vecs[i].c));
            check($sformatf("v%0d_ill", i), illegal, 32'(vecs[i].ill));
            check($sformatf("v%0d_pc", i), pc_out, 32'h1000 + 32'(i * 4));
            check($sformatf("v%0d_rdy", i), in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 0);
        check("drain_pc", pc_out, RPC);

        // Backpressure: A to main, B to skid, C held upstream
        out_ready = 1'b0; in_valid = 1'b1;
        pc_in = 32'h200; inst_in = 32'h0000_0085;
        tick();
        check("bp_a_valid", out_valid, 1);
        check("bp_a_rdy", in_ready, 1);
        pc_in = 32'h202; inst_in = 32'h0000_852E;
        tick();
        check("bp_b_rdy", in_ready, 0);
        check("bp_hold_inst", inst_out, 32'h0010_8093);
        pc_in = 32'h204; inst_in = 32'h0000_0013;
        tick();
        check("bp_c_rdy", in_ready, 0);
        check("bp_hold_pc", pc_out, 32'h200);
        check("bp_hold_inst2", inst_out, 32'h0010_8093);
        out_ready = 1'b1;
        tick();
        check("bp_b_inst", inst_out, 32'h00B0_0533);
        check("bp_b_pc", pc_out, 32'h202);
        check("bp_b_rdy2", in_ready, 1);
        tick();
        check("bp_c_inst", inst_out, 32'h0000_0013);
        check("bp_c_pc", pc_out, 32'h204);
        check("bp_c_is_c", is_compressed, 0);
        in_valid = 1'b0;
        tick();
        check("bp_end_valid", out_valid, 0);

        // Flush with main and skid full and a third input presented
        out_ready = 1'b0; in_valid = 1'b1;
        pc_in = 32'h300; inst_in = 32'h0000_40C0;
        tick();
        pc_in = 32'h302; inst_in = 32'h0000_C606;
        tick();
        check("fl_full_rdy", in_ready, 0);
        pc_in = 32'h304; inst_in = 32'h0000_9002; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_rdy", in_ready, 1);
        check("fl_pc", pc_out, RPC);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("fl_gone%0d", k), out_valid, 0);
        end

        // Asynchronous reset between edges while holding an instruction
        out_ready = 1'b0; in_valid = 1'b1;
        pc_in = 32'h400; inst_in = 32'h0000_852E;
        tick();
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_rdy", in_ready, 1);
        check("ar_pc", pc_out, RPC);
        check("ar_inst", inst_out, 32'h13);
        #1 reset = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        pc_in = 32'h500; inst_in = 32'h0000_0085;
        tick();
        in_valid = 1'b0;
        check("ar_post_valid", out_valid, 1);
        check("ar_post_inst", inst_out, 32'h0010_8093);
        check("ar_post_pc", pc_out, 32'h500);
        tick();
        check("ar_post_drain", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
